// File: rtl/fir_core.sv
// 8-tap sequential FIR: one multiply-accumulate per cycle, result held until the CSR reads it.
// Define FIR_SAT_EN to clamp overflowing sums to all-ones instead of wrapping modulo 2^18.
module fir_core #(
    parameter int TAPS = 8,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_in,
    output logic          sample_ready,
    input  logic [CW-1:0] coef0,
    input  logic [CW-1:0] coef1,
    input  logic [CW-1:0] coef2,
    input  logic [CW-1:0] coef3,
    input  logic [CW-1:0] coef4,
    input  logic [CW-1:0] coef5,
    input  logic [CW-1:0] coef6,
    input  logic [CW-1:0] coef7,
    input  logic          control,
    output logic [OW-1:0] dout,
    output logic          dout_valid,
    output logic          status
);

    localparam int PW = DW + CW;
    localparam int AW = PW + 3;
    localparam int IW = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [DW-1:0] r_x [TAPS];
    logic [AW-1:0] r_acc;
    logic [IW-1:0] r_idx;
    logic [OW-1:0] r_dout;
    logic          r_doutValid;

    logic [CW-1:0] w_coef [TAPS];
    logic [PW-1:0] w_prod;
    logic [AW-1:0] w_sum;
    logic [OW-1:0] w_result;
    logic          w_lastTap;

    assign w_coef[0] = coef0;
    assign w_coef[1] = coef1;
    assign w_coef[2] = coef2;
    assign w_coef[3] = coef3;
    assign w_coef[4] = coef4;
    assign w_coef[5] = coef5;
    assign w_coef[6] = coef6;
    assign w_coef[7] = coef7;

    assign w_prod    = PW'(r_x[r_idx]) * PW'(w_coef[r_idx]);
    assign w_sum     = r_acc + AW'(w_prod);
    assign w_lastTap = (r_idx == IW'(TAPS - 1));

`ifdef FIR_SAT_EN
    assign w_result = w_sum[AW-1] ? {OW{1'b1}} : w_sum[OW-1:0];
`else
    assign w_result = w_sum[OW-1:0];
`endif

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // In DONE the read strobe wins over a waiting sample; the sample is taken next cycle in IDLE.
    always_comb begin
        w_nextState  = r_state;
        status       = 1'b1;
        sample_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    w_nextState = MAC;
                end
            end
            MAC: begin
                status = 1'b0;
                if (w_lastTap) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (control) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0] <= sample_in;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                    if (w_lastTap) begin
                        r_dout      <= w_result;
                        r_doutValid <= 1'b1;
                    end
                end
                DONE: begin
                    if (control) begin
                        r_doutValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_core.sv
// Directed bench for fir_core: a cycle-level reference model checked every cycle, plus literal expectations.
// Build with FIR_SAT_EN defined to expect clamped rather than wrapped overflow.
module tb_fir_core;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [7:0]  sample_in;
    logic        sample_ready;
    logic [7:0]  coef [8];
    logic        control;
    logic [17:0] dout;
    logic        dout_valid;
    logic        status;

    int checks   = 0;
    int failures = 0;
    int cycleCnt = 0;

    int mHist [8];
    int mBusy      = 0;
    bit mHasResult = 1'b0;
    int mDout      = 0;
    int mPending   = 0;
    bit mInit      = 1'b0;

    fir_core dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .coef0        (coef[0]),
        .coef1        (coef[1]),
        .coef2        (coef[2]),
        .coef3        (coef[3]),
        .coef4        (coef[4]),
        .coef5        (coef[5]),
        .coef6        (coef[6]),
        .coef7        (coef[7]),
        .control      (control),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .status       (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int reduceSum(input int s);
`ifdef FIR_SAT_EN
        return (s > 262143) ? 262143 : s;
`else
        return s % 262144;
`endif
    endfunction

    // Reference model: a sample's result appears 9 cycles after its accept and stays until read.
    initial begin
        forever begin
            @(posedge clk);
            cycleCnt++;
            if (rst) begin
                for (int k = 0; k < 8; k++) mHist[k] = 0;
                mBusy      = 0;
                mHasResult = 1'b0;
                mDout      = 0;
                mInit      = 1'b1;
            end else if (mInit) begin
                if (mBusy > 0) begin
                    mBusy--;
                    if (mBusy == 0) begin
                        mHasResult = 1'b1;
                        mDout      = mPending;
                    end
                end else if (mHasResult) begin
                    if (control) mHasResult = 1'b0;
                end else if (sample_valid) begin
                    int sum;
                    for (int k = 7; k > 0; k--) mHist[k] = mHist[k-1];
                    mHist[0] = int'(sample_in);
                    sum = 0;
                    for (int k = 0; k < 8; k++) sum += mHist[k] * int'(coef[k]);
                    mPending = reduceSum(sum);
                    mBusy    = 8;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mInit) begin
                checkOutput("model_status", 32'(status), 32'(mBusy == 0));
                checkOutput("model_ready", 32'(sample_ready), 32'((mBusy == 0) && !mHasResult));
                checkOutput("model_dout_valid", 32'(dout_valid), 32'(mHasResult));
                checkOutput("model_dout", 32'(dout), 32'(mDout));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] s, input logic c);
        sample_valid = v;
        sample_in    = s;
        control      = c;
    endtask

    task automatic waitResult(input int acceptCycle, input string name);
        int n;
        n = 0;
        while (!dout_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({name, "_latency"}, 32'(cycleCnt - acceptCycle), 32'd9);
    endtask

    task automatic readResult();
        applyStimulus(1'b0, 8'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0);
    endtask

    task automatic runSample(input logic [7:0] s, input string name, input int expDout, input bit checkLit);
        int acceptCycle;
        applyStimulus(1'b1, s, 1'b0);
        acceptCycle = cycleCnt;
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0);
        waitResult(acceptCycle, name);
        if (checkLit) checkOutput({name, "_dout"}, 32'(dout), 32'(expDout));
        readResult();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acceptCycle;
        int busyCycles;
        int n;

        applyStimulus(1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 8; k++) coef[k] = 8'(k + 1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_status", 32'(status), 32'd1);
        checkOutput("reset_ready", 32'(sample_ready), 32'd1);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_dout_valid", 32'(dout_valid), 32'd0);

        // Impulse through coefficients 1..8 walks out the taps in order.
        for (int i = 0; i < 8; i++) begin
            runSample((i == 0) ? 8'd1 : 8'd0, "impulse", i + 1, 1'b1);
        end

        applyStimulus(1'b0, 8'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("stray_dout", 32'(dout), 32'd8);
        checkOutput("stray_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("stray_ready", 32'(sample_ready), 32'd1);

        applyStimulus(1'b1, 8'd7, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset_status", 32'(status), 32'd1);
        checkOutput("midreset_ready", 32'(sample_ready), 32'd1);
        checkOutput("midreset_dout", 32'(dout), 32'd0);
        checkOutput("midreset_dout_valid", 32'(dout_valid), 32'd0);
        runSample(8'd3, "post_reset", 3, 1'b1);

        // Held valid: history 5,3 gives 5*1 + 3*2.
        applyStimulus(1'b1, 8'd5, 1'b0);
        tick();
        busyCycles = 0;
        n = 0;
        while (!dout_valid && n < 20) begin
            if (!status) busyCycles++;
            tick();
            n++;
        end
        checkOutput("busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("busy_dout", 32'(dout), 32'd11);
        tick();
        checkOutput("done_ready", 32'(sample_ready), 32'd0);
        checkOutput("done_dout_valid", 32'(dout_valid), 32'd1);

        applyStimulus(1'b1, 8'd5, 1'b1);
        tick();
        checkOutput("simul_dout_valid", 32'(dout_valid), 32'd0);
        checkOutput("simul_status", 32'(status), 32'd1);
        checkOutput("simul_ready", 32'(sample_ready), 32'd1);
        applyStimulus(1'b1, 8'd5, 1'b0);
        acceptCycle = cycleCnt;
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("simul_accept_status", 32'(status), 32'd0);
        waitResult(acceptCycle, "second");
        checkOutput("second_dout", 32'(dout), 32'd24);
        readResult();

        for (int k = 0; k < 8; k++) coef[k] = 8'd255;
        for (int i = 0; i < 8; i++) begin
`ifdef FIR_SAT_EN
            runSample(8'd255, "sat", 32'h3FFFF, i == 7);
`else
            runSample(8'd255, "sat", 32'h3F008, i == 7);
`endif
        end

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
